// File: rtl/sal_bank_timer_if.sv
// Timing parameter bundle published by the controller's timing register block.
// Each field holds an interval minus one, in controller clock cycles.
interface TIMING_IF #(
  parameter int TW = 8
);
  logic [TW-1:0] t_rcd_m1;
  logic [TW-1:0] t_ras_m1;
  logic [TW-1:0] t_rp_m1;
  logic [TW-1:0] t_rtp_m1;
  logic [TW-1:0] t_wtp_m1;

  modport SRC (output t_rcd_m1, t_ras_m1, t_rp_m1, t_rtp_m1, t_wtp_m1);
  modport DST (input  t_rcd_m1, t_ras_m1, t_rp_m1, t_rtp_m1, t_wtp_m1);
endinterface

// File: rtl/sal_bank_timer.sv
// Per-bank row-state tracker: says when ACT, RD/WR and PRE are legal for one bank
// and flags any grant pattern the scheduler should never have produced.
module sal_bank_timer #(
  parameter int RA_W = 16,
  parameter int TW   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  TIMING_IF.DST           timing_if,
  input  logic            act_gnt,
  input  logic [RA_W-1:0] act_ra,
  input  logic            rd_gnt,
  input  logic            wr_gnt,
  input  logic            pre_gnt,
  output logic            act_ok,
  output logic            rdwr_ok,
  output logic            pre_ok,
  output logic            is_open,
  output logic [RA_W-1:0] cur_ra,
  output logic            proto_err
);

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_ACTIVATING  = 2'd1,
    ST_ACTIVE      = 2'd2,
    ST_PRECHARGING = 2'd3
  } state_t;

  localparam logic [TW-1:0] CNT_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] CNT_ONE  = {{(TW-1){1'b0}}, 1'b1};

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] v);
    logic [TW-1:0] r;
    if (v == CNT_ZERO) begin
      r = CNT_ZERO;
    end else begin
      r = v - CNT_ONE;
    end
    return r;
  endfunction

  function automatic logic [TW-1:0] max_tw(input logic [TW-1:0] a, input logic [TW-1:0] b);
    logic [TW-1:0] r;
    if (a > b) begin
      r = a;
    end else begin
      r = b;
    end
    return r;
  endfunction

  state_t          state_r,   state_nx_s;
  logic [TW-1:0]   cnt_r,     cnt_nx_s;
  logic [TW-1:0]   ras_cnt_r, ras_nx_s;
  logic [TW-1:0]   wp_cnt_r,  wp_nx_s;
  logic [RA_W-1:0] cur_ra_r,  ra_nx_s;
  logic            proto_err_r, err_nx_s;

  logic cnt_zero_s;
  logic act_ok_s, rdwr_ok_s, pre_ok_s;
  logic any_gnt_s, multi_gnt_s;
  logic acc_act_s, acc_rd_s, acc_wr_s, acc_pre_s, bad_gnt_s;

  // Legality flags depend on registered state only, never on the grant inputs.
  always_comb begin
    cnt_zero_s = (cnt_r == CNT_ZERO);
    act_ok_s   = (state_r == ST_IDLE) | ((state_r == ST_PRECHARGING) & cnt_zero_s);
    rdwr_ok_s  = (state_r == ST_ACTIVE) | ((state_r == ST_ACTIVATING) & cnt_zero_s);
    pre_ok_s   = rdwr_ok_s & (ras_cnt_r == CNT_ZERO) & (wp_cnt_r == CNT_ZERO);
  end

  // Grant qualification: exactly one grant, and it must be legal this cycle.
  always_comb begin
    any_gnt_s   = act_gnt | rd_gnt | wr_gnt | pre_gnt;
    multi_gnt_s = (act_gnt & rd_gnt) | (act_gnt & wr_gnt) | (act_gnt & pre_gnt) |
                  (rd_gnt & wr_gnt) | (rd_gnt & pre_gnt) | (wr_gnt & pre_gnt);
    acc_act_s   = act_gnt & ~multi_gnt_s & act_ok_s;
    acc_rd_s    = rd_gnt  & ~multi_gnt_s & rdwr_ok_s;
    acc_wr_s    = wr_gnt  & ~multi_gnt_s & rdwr_ok_s;
    acc_pre_s   = pre_gnt & ~multi_gnt_s & pre_ok_s;
    bad_gnt_s   = any_gnt_s & ~(acc_act_s | acc_rd_s | acc_wr_s | acc_pre_s);
  end

  // Next-state: counters free-run down to zero unless an accepted grant reloads them.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = sat_dec(cnt_r);
    ras_nx_s   = sat_dec(ras_cnt_r);
    wp_nx_s    = sat_dec(wp_cnt_r);
    ra_nx_s    = cur_ra_r;
    err_nx_s   = proto_err_r | bad_gnt_s;

    // A later RD/WR can only extend the write-to-precharge wait, never shorten it.
    if (acc_rd_s) begin
      wp_nx_s = max_tw(sat_dec(wp_cnt_r), timing_if.t_rtp_m1);
    end else if (acc_wr_s) begin
      wp_nx_s = max_tw(sat_dec(wp_cnt_r), timing_if.t_wtp_m1);
    end else begin
      wp_nx_s = sat_dec(wp_cnt_r);
    end

    case (state_r)
      ST_IDLE, ST_PRECHARGING: begin
        if (acc_act_s) begin
          state_nx_s = ST_ACTIVATING;
          cnt_nx_s   = timing_if.t_rcd_m1;
          ras_nx_s   = timing_if.t_ras_m1;
          wp_nx_s    = CNT_ZERO;
          ra_nx_s    = act_ra;
        end else if ((state_r == ST_PRECHARGING) && cnt_zero_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_ACTIVATING, ST_ACTIVE: begin
        if (acc_pre_s) begin
          state_nx_s = ST_PRECHARGING;
          cnt_nx_s   = timing_if.t_rp_m1;
        end else if ((state_r == ST_ACTIVATING) && cnt_zero_s) begin
          state_nx_s = ST_ACTIVE;
        end else begin
          state_nx_s = state_r;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      ras_cnt_r   <= CNT_ZERO;
      wp_cnt_r    <= CNT_ZERO;
      cur_ra_r    <= {RA_W{1'b0}};
      proto_err_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      cnt_r       <= cnt_nx_s;
      ras_cnt_r   <= ras_nx_s;
      wp_cnt_r    <= wp_nx_s;
      cur_ra_r    <= ra_nx_s;
      proto_err_r <= err_nx_s;
    end
  end

  assign act_ok    = act_ok_s;
  assign rdwr_ok   = rdwr_ok_s;
  assign pre_ok    = pre_ok_s;
  assign is_open   = (state_r == ST_ACTIVATING) | (state_r == ST_ACTIVE);
  assign cur_ra    = cur_ra_r;
  assign proto_err = proto_err_r;

endmodule

// File: tb/tb_sal_bank_timer.sv
// Bench for sal_bank_timer: directed test-plan scenarios, then random grants checked
// against a model that tracks absolute "legal-from" cycle numbers per command.
module tb_sal_bank_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        act_gnt = 1'b0, rd_gnt = 1'b0, wr_gnt = 1'b0, pre_gnt = 1'b0;
  logic [15:0] act_ra = 16'h0000;
  logic        act_ok, rdwr_ok, pre_ok, is_open, proto_err;
  logic [15:0] cur_ra;

  TIMING_IF #(.TW(8)) tif ();

  sal_bank_timer #(.RA_W(16), .TW(8)) dut (
    .clk(clk), .rst_n(rst_n), .timing_if(tif),
    .act_gnt(act_gnt), .act_ra(act_ra), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .pre_gnt(pre_gnt),
    .act_ok(act_ok), .rdwr_ok(rdwr_ok), .pre_ok(pre_ok), .is_open(is_open),
    .cur_ra(cur_ra), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit armed = 1'b0;

  // Reference model: absolute cycle numbers from which each command becomes legal.
  int          c = 0;
  bit          m_open = 1'b0;
  int          m_act_at = 0, m_rdwr_at = 0, m_ras_at = 0, m_wp_at = 0;
  logic [15:0] m_ra = 16'h0000;
  bit          m_err = 1'b0;

  function automatic bit f_act_ok();
    return !m_open && (c >= m_act_at);
  endfunction
  function automatic bit f_rdwr_ok();
    return m_open && (c >= m_rdwr_at);
  endfunction
  function automatic bit f_pre_ok();
    return f_rdwr_ok() && (c >= m_ras_at) && (c >= m_wp_at);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("act_ok",    {15'd0, act_ok},    {15'd0, f_act_ok()});
    chk("rdwr_ok",   {15'd0, rdwr_ok},   {15'd0, f_rdwr_ok()});
    chk("pre_ok",    {15'd0, pre_ok},    {15'd0, f_pre_ok()});
    chk("is_open",   {15'd0, is_open},   {15'd0, m_open});
    chk("cur_ra",    cur_ra,             m_ra);
    chk("proto_err", {15'd0, proto_err}, {15'd0, m_err});
  endtask

  task automatic model_advance();
    int  n;
    bit  legal;
    if (!rst_n) begin
      m_open = 1'b0; m_act_at = 0; m_rdwr_at = 0; m_ras_at = 0; m_wp_at = 0;
      m_ra = 16'h0000; m_err = 1'b0;
    end else begin
      n = int'(act_gnt) + int'(rd_gnt) + int'(wr_gnt) + int'(pre_gnt);
      legal = (n == 1) && ((act_gnt && f_act_ok()) || (rd_gnt && f_rdwr_ok()) ||
                           (wr_gnt && f_rdwr_ok()) || (pre_gnt && f_pre_ok()));
      if (n != 0 && !legal) begin
        m_err = 1'b1;
      end else if (legal && act_gnt) begin
        m_open    = 1'b1;
        m_rdwr_at = c + int'(tif.t_rcd_m1) + 1;
        m_ras_at  = c + int'(tif.t_ras_m1) + 1;
        m_wp_at   = 0;
        m_ra      = act_ra;
      end else if (legal && rd_gnt) begin
        if (c + int'(tif.t_rtp_m1) + 1 > m_wp_at) m_wp_at = c + int'(tif.t_rtp_m1) + 1;
      end else if (legal && wr_gnt) begin
        if (c + int'(tif.t_wtp_m1) + 1 > m_wp_at) m_wp_at = c + int'(tif.t_wtp_m1) + 1;
      end else if (legal && pre_gnt) begin
        m_open   = 1'b0;
        m_act_at = c + int'(tif.t_rp_m1) + 1;
      end
    end
    c++;
  endtask

  // One clock: check current outputs, drive this cycle's inputs, advance model and clock.
  task automatic step(input bit rs, input logic a, input logic r, input logic w,
                      input logic p, input logic [15:0] ra);
    if (armed) check_all();
    rst_n = !rs; act_gnt = a; rd_gnt = r; wr_gnt = w; pre_gnt = p; act_ra = ra;
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
  endtask

  task automatic plan_timing();
    tif.t_rcd_m1 = 8'd3; tif.t_ras_m1 = 8'd9; tif.t_rp_m1 = 8'd3;
    tif.t_rtp_m1 = 8'd1; tif.t_wtp_m1 = 8'd7;
  endtask

  initial begin
    int sel, k;
    logic a, r, w, p;
    plan_timing();
    do_reset();
    armed = 1'b1;
    chk("rst_act_ok", {15'd0, act_ok}, 16'h0001);
    chk("rst_rdwr_ok", {15'd0, rdwr_ok}, 16'h0000);
    chk("rst_pre_ok", {15'd0, pre_ok}, 16'h0000);
    chk("rst_is_open", {15'd0, is_open}, 16'h0000);
    chk("rst_cur_ra", cur_ra, 16'h0000);
    chk("rst_proto_err", {15'd0, proto_err}, 16'h0000);

    // ACT at 0: open at 1, RD/WR legal at 4, PRE legal at 10, ACT again 4 after PRE.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234);
    chk("s1_cur_ra_c1", cur_ra, 16'h1234);
    chk("s1_open_c1", {15'd0, is_open}, 16'h0001);
    idle(2);
    chk("s1_rdwr_c3", {15'd0, rdwr_ok}, 16'h0000);
    idle(1);
    chk("s1_rdwr_c4", {15'd0, rdwr_ok}, 16'h0001);
    idle(5);
    chk("s1_pre_c9", {15'd0, pre_ok}, 16'h0000);
    idle(1);
    chk("s1_pre_c10", {15'd0, pre_ok}, 16'h0001);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    idle(3);
    chk("s1_act_c14", {15'd0, act_ok}, 16'h0001);
    chk("s1_ra_hold", cur_ra, 16'h1234);

    // ACT 0, WR 5, RD 6: WR bound (13) dominates; PRE 13 -> ACT legal 17.
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hbeef);
    idle(4);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    idle(5);
    chk("s2_pre_c12", {15'd0, pre_ok}, 16'h0000);
    idle(1);
    chk("s2_pre_c13", {15'd0, pre_ok}, 16'h0001);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    idle(2);
    chk("s2_act_c16", {15'd0, act_ok}, 16'h0000);
    idle(1);
    chk("s2_act_c17", {15'd0, act_ok}, 16'h0001);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0777);
    chk("s2_reopen", {15'd0, is_open}, 16'h0001);
    chk("s2_reopen_ra", cur_ra, 16'h0777);

    // ACT 0, RD 9: PRE low at 10, high at 11.
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0042);
    idle(8);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("s3_pre_c10", {15'd0, pre_ok}, 16'h0000);
    idle(1);
    chk("s3_pre_c11", {15'd0, pre_ok}, 16'h0001);

    // Illegal grants.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("s4_rd_idle_err", {15'd0, proto_err}, 16'h0001);
    chk("s4_rd_idle_closed", {15'd0, is_open}, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0aaa);
    idle(5);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0555);
    chk("s4_actpre_open", {15'd0, is_open}, 16'h0001);
    chk("s4_actpre_ra", cur_ra, 16'h0aaa);
    idle(3);
    chk("s4_err_sticky", {15'd0, proto_err}, 16'h0001);

    // tRCD changed mid-countdown has no effect.
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0101);
    idle(1);
    tif.t_rcd_m1 = 8'd0;
    idle(1);
    chk("s5_rdwr_c3", {15'd0, rdwr_ok}, 16'h0000);
    idle(1);
    chk("s5_rdwr_c4", {15'd0, rdwr_ok}, 16'h0001);
    plan_timing();

    // All fields zero: one-cycle spacing ACT -> PRE -> ACT.
    do_reset();
    tif.t_rcd_m1 = 8'd0; tif.t_ras_m1 = 8'd0; tif.t_rp_m1 = 8'd0;
    tif.t_rtp_m1 = 8'd0; tif.t_wtp_m1 = 8'd0;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0011);
    chk("s6_rdwr_t1", {15'd0, rdwr_ok}, 16'h0001);
    chk("s6_pre_t1", {15'd0, pre_ok}, 16'h0001);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    chk("s6_act_t2", {15'd0, act_ok}, 16'h0001);

    // Random grants against the model, with occasional timing changes and resets.
    for (int i = 0; i < 2500; i++) begin
      if (i % 64 == 0) begin
        tif.t_rcd_m1 = 8'($urandom_range(0, 5)); tif.t_ras_m1 = 8'($urandom_range(0, 9));
        tif.t_rp_m1  = 8'($urandom_range(0, 5)); tif.t_rtp_m1 = 8'($urandom_range(0, 4));
        tif.t_wtp_m1 = 8'($urandom_range(0, 8));
      end
      sel = $urandom_range(0, 99);
      a = 1'b0; r = 1'b0; w = 1'b0; p = 1'b0;
      if (sel < 70) begin
        k = $urandom_range(0, 3);
        case (k)
          0: a = f_act_ok();
          1: r = f_rdwr_ok();
          2: w = f_rdwr_ok();
          default: p = f_pre_ok();
        endcase
      end else if (sel >= 92) begin
        {a, r, w, p} = 4'($urandom);
      end
      step(($urandom_range(0, 149) == 0), a, r, w, p, 16'($urandom));
    end
    check_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
